round_controller: RTL and testbench
===================================

# round_controller

Per-round penalty sequencer for SOLO (keeper) mode. It tracks each shot from release to arrival, decides save vs goal, and keeps the save score and round index. It produces the `is_scored` / `round_counter` / `score` control fields that the next-state controller samples to leave KEEPER for WINNER or LOOSER. It sits between the ball/keeper datapath and the control bus, and it is the only writer of those three fields.

## Interface
Parameters:
- `ROUNDS`, 5: rounds per game; legal range 1..15.
- `TIMEOUT`, 100_000_000: max FLIGHT cycles before a shot is declared missed; must be ≥ 2.
- `GAP_CYCLES`, 65_000_000: cool-down cycles after each reported round; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `game_state`  in  `g_state` (game_pkg)  current registered game state.
- `shot_start`  in  1  one-cycle pulse: ball released.
- `shot_zone`  in  3  target zone 0..5; sampled only with `shot_start`.
- `ball_arrived`  in  1  one-cycle pulse: ball reached the goal line.
- `keeper_zone`  in  3  zone covered by the keeper; sampled only with `ball_arrived`.
- `is_scored`  out  1  one-cycle pulse: the round result has been committed.
- `round_counter`  out  4  index of the round being played (0..ROUNDS-1), or ROUNDS once finished.
- `score`  out  3  number of saves; saturates at 7.
- `goal`  out  1  result of the last round (1 = goal conceded); held until the next report.
- `round_active`  out  1  high in WAIT_SHOT and FLIGHT.

## Operation
- FSM states: IDLE, WAIT_SHOT, FLIGHT, REPORT, GAP, FINISHED.
- Reset values: state IDLE; all outputs 0; internal shot-zone latch 0; internal timers 0.
- Priority 1, START: when `game_state` == START in any FSM state, the next state is IDLE and `round_counter`, `score` and `goal` are cleared to 0.
- Priority 2, other states: `game_state` not KEEPER and not START forces IDLE. Counters are held, so WINNER/LOOSER keep the final values visible.
- IDLE → WAIT_SHOT when `game_state` == KEEPER and `round_counter` < ROUNDS.
- IDLE → FINISHED when `game_state` == KEEPER and `round_counter` == ROUNDS.
- WAIT_SHOT → FLIGHT on `shot_start`. The same cycle latches `shot_zone` and clears the flight timer.
- FLIGHT:
  - The timer increments every cycle.
  - On `ball_arrived`: `goal` = (`keeper_zone` != latched zone). If `goal` is 0, `score` increments, saturating at 7. Next state is REPORT.
  - If the timer reaches TIMEOUT-1 with no arrival, the shot is missed: `goal` = 0, `score` increments, next state is REPORT.
  - If arrival and timeout occur in the same cycle, arrival wins.
  - `shot_start` is ignored in FLIGHT.
- REPORT, one cycle only:
  - `is_scored` = 1.
  - `score` and `goal` already include this round.
  - `round_counter` still holds this round's index.
  - On exit, `round_counter` increments.
  - Next state is FINISHED if the incremented value equals ROUNDS, else GAP. The GAP timer is cleared on entry.
- GAP: `shot_start` and `ball_arrived` are ignored. After GAP_CYCLES cycles, next state is WAIT_SHOT.
- FINISHED: holds all outputs. Leaves only through START (→ IDLE) or another non-KEEPER state (→ IDLE).
- `ball_arrived` outside FLIGHT is ignored. `shot_zone` values 6..7 are compared as-is, with no clamping.
- A mid-round START (abandoned game) discards the round with no `is_scored` pulse.

## Timing
- `shot_start` in cycle t: state = FLIGHT at t+1.
- `ball_arrived` in cycle a (in FLIGHT): at a+1, `is_scored` = 1 and `score`/`goal` are updated. At a+2, `round_counter` is incremented and `is_scored` = 0.
- Timeout: a shot released at t, never arriving, produces `is_scored` at t+TIMEOUT+1.
- First accepted `shot_start` after a report: report cycle + GAP_CYCLES + 1, i.e. the first cycle in WAIT_SHOT.
- START observed in cycle s: counters are 0 and state is IDLE at s+1.
- `rst` has priority over everything; all outputs are 0 on the cycle after `rst` is sampled high.
- All outputs are registered; no combinational input → output path.

## Test plan
- Reset, then KEEPER: `shot_start` with zone 2; `ball_arrived` 10 cycles later with keeper_zone 2 → one `is_scored` pulse, `score` = 1, `goal` = 0, `round_counter` = 0 during the pulse and 1 the next cycle.
- Full game of 5 rounds with saves on rounds 0, 2, 4 (mismatched zones on 1, 3) → final pulse shows `round_counter` = 4 and `score` = 3. After it, `round_counter` = 5, state FINISHED, further shots ignored.
- TIMEOUT = 20, shot with no arrival → `is_scored` 21 cycles after `shot_start`, `goal` = 0, `score` +1. With `ball_arrived` on the same cycle as expiry and zones mismatched → `goal` = 1.
- `shot_start` during GAP and during FLIGHT, and `ball_arrived` in WAIT_SHOT → no state change and no pulse. A shot released exactly at the first WAIT_SHOT cycle is accepted.
- Mid-flight START → no `is_scored`; `score`/`round_counter`/`goal` = 0 the next cycle. WINNER after 5 rounds → values held until START.
- `rst` asserted during REPORT → `is_scored` low next cycle and all outputs 0.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : game_pkg                                                  |
// | Brief    : Shared game-level state encoding for the control bus.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package game_pkg;

  // Registered game state as seen by the per-mode sequencers
  typedef enum logic [1:0] {
    START  = 2'd0,
    KEEPER = 2'd1,
    WINNER = 2'd2,
    LOOSER = 2'd3
  } g_state;

endpackage
`default_nettype wire

// File: rtl/round_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : round_controller                                          |
// | Brief    : Per-round penalty sequencer for keeper mode. Tracks each  |
// |            shot from release to arrival, decides save vs goal and    |
// |            owns the is_scored / round_counter / score fields.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module round_controller
  import game_pkg::*;
#(
  parameter int ROUNDS     = 5,
  parameter int TIMEOUT    = 100_000_000,
  parameter int GAP_CYCLES = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  g_state     game_state,
  input  logic       shot_start,
  input  logic [2:0] shot_zone,
  input  logic       ball_arrived,
  input  logic [2:0] keeper_zone,
  output logic       is_scored,
  output logic [3:0] round_counter,
  output logic [2:0] score,
  output logic       goal,
  output logic       round_active
);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_WAIT     = 3'd1;
  localparam logic [2:0] c_ST_FLIGHT   = 3'd2;
  localparam logic [2:0] c_ST_REPORT   = 3'd3;
  localparam logic [2:0] c_ST_GAP      = 3'd4;
  localparam logic [2:0] c_ST_FINISHED = 3'd5;

  localparam logic [3:0]  c_ROUNDS   = 4'(ROUNDS);
  localparam logic [31:0] c_TO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [31:0] c_GAP_LAST = 32'(GAP_CYCLES - 1);

  logic [2:0]  r_state;
  logic [31:0] r_timer;
  logic [2:0]  r_zone;
  logic        r_is_scored;
  logic [3:0]  r_round_counter;
  logic [2:0]  r_score;
  logic        r_goal;
  logic        r_round_active;

  logic [2:0]  w_state_nxt;
  logic [31:0] w_timer_nxt;
  logic [2:0]  w_zone_nxt;
  logic [3:0]  w_rc_nxt;
  logic [2:0]  w_score_nxt;
  logic        w_goal_nxt;
  logic [2:0]  w_score_inc;
  logic [3:0]  w_rc_inc;

  // Saturating save count and next round index, shared by several branches
  assign w_score_inc = (r_score == 3'd7) ? 3'd7 : r_score + 3'd1;
  assign w_rc_inc    = r_round_counter + 4'd1;

  // Next-state and next-value decode; START and foreign game states override the FSM
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_zone_nxt  = r_zone;
    w_rc_nxt    = r_round_counter;
    w_score_nxt = r_score;
    w_goal_nxt  = r_goal;
    if (game_state == START) begin
      w_state_nxt = c_ST_IDLE;
      w_rc_nxt    = 4'd0;
      w_score_nxt = 3'd0;
      w_goal_nxt  = 1'b0;
    end else if (game_state != KEEPER) begin
      // Counters held so WINNER/LOOSER screens still show the final result
      w_state_nxt = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          w_state_nxt = (r_round_counter < c_ROUNDS) ? c_ST_WAIT : c_ST_FINISHED;
        end
        c_ST_WAIT: begin
          if (shot_start) begin
            w_zone_nxt  = shot_zone;
            w_timer_nxt = 32'd0;
            w_state_nxt = c_ST_FLIGHT;
          end
        end
        c_ST_FLIGHT: begin
          w_timer_nxt = r_timer + 32'd1;
          // Arrival is checked first so it wins over a coincident timeout
          if (ball_arrived) begin
            w_goal_nxt  = (keeper_zone != r_zone);
            if (keeper_zone == r_zone) begin
              w_score_nxt = w_score_inc;
            end
            w_state_nxt = c_ST_REPORT;
          end else if (r_timer == c_TO_LAST) begin
            // A shot that never arrives counts as a save
            w_goal_nxt  = 1'b0;
            w_score_nxt = w_score_inc;
            w_state_nxt = c_ST_REPORT;
          end
        end
        c_ST_REPORT: begin
          w_rc_nxt    = w_rc_inc;
          w_timer_nxt = 32'd0;
          w_state_nxt = (w_rc_inc == c_ROUNDS) ? c_ST_FINISHED : c_ST_GAP;
        end
        c_ST_GAP: begin
          w_timer_nxt = r_timer + 32'd1;
          if (r_timer == c_GAP_LAST) begin
            w_state_nxt = c_ST_WAIT;
          end
        end
        c_ST_FINISHED: begin
          w_state_nxt = c_ST_FINISHED;
        end
        default: begin
          w_state_nxt = c_ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; outputs are derived from the next state so they stay registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= c_ST_IDLE;
      r_timer         <= 32'd0;
      r_zone          <= 3'd0;
      r_is_scored     <= 1'b0;
      r_round_counter <= 4'd0;
      r_score         <= 3'd0;
      r_goal          <= 1'b0;
      r_round_active  <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_timer         <= w_timer_nxt;
      r_zone          <= w_zone_nxt;
      r_is_scored     <= (w_state_nxt == c_ST_REPORT);
      r_round_counter <= w_rc_nxt;
      r_score         <= w_score_nxt;
      r_goal          <= w_goal_nxt;
      r_round_active  <= (w_state_nxt == c_ST_WAIT) || (w_state_nxt == c_ST_FLIGHT);
    end
  end

  assign is_scored     = r_is_scored;
  assign round_counter = r_round_counter;
  assign score         = r_score;
  assign goal          = r_goal;
  assign round_active  = r_round_active;

endmodule
`default_nettype wire

// File: tb/tb_round_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_round_controller                                       |
// | Brief    : Self-checking bench for round_controller: directed        |
// |            scenarios plus random play against a deadline-based       |
// |            reference model.                                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_round_controller;
  import game_pkg::*;

  localparam int ROUNDS     = 5;
  localparam int TIMEOUT    = 20;
  localparam int GAP_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst;
  g_state     game_state;
  logic       shot_start;
  logic [2:0] shot_zone;
  logic       ball_arrived;
  logic [2:0] keeper_zone;
  logic       is_scored;
  logic [3:0] round_counter;
  logic [2:0] score;
  logic       goal;
  logic       round_active;

  round_controller #(
    .ROUNDS(ROUNDS),
    .TIMEOUT(TIMEOUT),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .game_state(game_state),
    .shot_start(shot_start),
    .shot_zone(shot_zone),
    .ball_arrived(ball_arrived),
    .keeper_zone(keeper_zone),
    .is_scored(is_scored),
    .round_counter(round_counter),
    .score(score),
    .goal(goal),
    .round_active(round_active)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: phase name plus absolute-cycle deadlines
  string      m_mode = "idle";
  int         m_rc = 0;
  int         m_score = 0;
  int         m_goal = 0;
  int         m_scored = 0;
  int         m_active = 0;
  logic [2:0] m_zone = 3'd0;
  longint     m_deadline = 0;
  longint     m_resume = 0;
  longint     cyc = 0;

  task automatic model_save();
    if (m_score < 7) m_score++;
  endtask

  task automatic model_step();
    if (rst) begin
      m_mode = "idle"; m_rc = 0; m_score = 0; m_goal = 0; m_zone = 3'd0;
    end else if (game_state == START) begin
      m_mode = "idle"; m_rc = 0; m_score = 0; m_goal = 0;
    end else if (game_state != KEEPER) begin
      m_mode = "idle";
    end else if (m_mode == "idle") begin
      m_mode = (m_rc == ROUNDS) ? "done" : "wait";
    end else if (m_mode == "wait") begin
      if (shot_start) begin
        m_zone = shot_zone;
        m_deadline = cyc + TIMEOUT;
        m_mode = "flight";
      end
    end else if (m_mode == "flight") begin
      if (ball_arrived) begin
        m_goal = (keeper_zone != m_zone) ? 1 : 0;
        if (m_goal == 0) model_save();
        m_mode = "report";
      end else if (cyc == m_deadline) begin
        m_goal = 0;
        model_save();
        m_mode = "report";
      end
    end else if (m_mode == "report") begin
      m_rc++;
      if (m_rc == ROUNDS) m_mode = "done";
      else begin
        m_resume = cyc + GAP_CYCLES + 1;
        m_mode = "gap";
      end
    end else if (m_mode == "gap") begin
      if (cyc + 1 == m_resume) m_mode = "wait";
    end
    m_scored = (m_mode == "report") ? 1 : 0;
    m_active = (m_mode == "wait" || m_mode == "flight") ? 1 : 0;
  endtask

  // One clock: model sees the same inputs as the DUT, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check("is_scored", 32'(is_scored), 32'(m_scored));
    check("round_counter", 32'(round_counter), 32'(m_rc));
    check("score", 32'(score), 32'(m_score));
    check("goal", 32'(goal), 32'(m_goal));
    check("round_active", 32'(round_active), 32'(m_active));
  endtask

  task automatic wait_active();
    for (int i = 0; i < 200; i++) begin
      if (round_active) return;
      tick();
    end
    check("wait_active_bound", 32'(round_active), 1);
  endtask

  logic [2:0] z;
  int         k;
  int         hold;

  initial begin
    rst = 1'b1; game_state = WINNER; shot_start = 1'b0; shot_zone = 3'd0;
    ball_arrived = 1'b0; keeper_zone = 3'd0;
    tick(); tick();
    check("rst_is_scored", 32'(is_scored), 0);
    check("rst_round_counter", 32'(round_counter), 0);
    check("rst_score", 32'(score), 0);
    check("rst_active", 32'(round_active), 0);
    rst = 1'b0;

    // First round: save in zone 2, arrival 10 cycles after release
    game_state = KEEPER;
    wait_active();
    shot_start = 1'b1; shot_zone = 3'd2; tick(); shot_start = 1'b0;
    repeat (9) tick();
    ball_arrived = 1'b1; keeper_zone = 3'd2; tick(); ball_arrived = 1'b0;
    check("r0_pulse", 32'(is_scored), 1);
    check("r0_score", 32'(score), 1);
    check("r0_goal", 32'(goal), 0);
    check("r0_rc_during", 32'(round_counter), 0);
    tick();
    check("r0_rc_after", 32'(round_counter), 1);
    check("r0_pulse_end", 32'(is_scored), 0);

    // Full game: saves on even rounds, goals on odd rounds
    game_state = START; tick();
    check("start_rc", 32'(round_counter), 0);
    check("start_score", 32'(score), 0);
    game_state = KEEPER;
    for (int r = 0; r < ROUNDS; r++) begin
      wait_active();
      z = 3'($urandom_range(0, 5));
      shot_start = 1'b1; shot_zone = z; tick(); shot_start = 1'b0;
      repeat (3) tick();
      ball_arrived = 1'b1; keeper_zone = (r % 2 == 0) ? z : (z ^ 3'd1); tick(); ball_arrived = 1'b0;
    end
    check("fin_pulse", 32'(is_scored), 1);
    check("fin_rc_pulse", 32'(round_counter), 4);
    check("fin_score", 32'(score), 3);
    tick();
    check("fin_rc", 32'(round_counter), 5);
    check("fin_active", 32'(round_active), 0);
    shot_start = 1'b1; tick(); shot_start = 1'b0;
    repeat (5) tick();
    check("fin_ignore_rc", 32'(round_counter), 5);
    game_state = WINNER; repeat (4) tick();
    check("win_score", 32'(score), 3);
    check("win_rc", 32'(round_counter), 5);
    game_state = START; tick();
    check("restart_rc", 32'(round_counter), 0);
    check("restart_score", 32'(score), 0);

    // Timeout: shot never arrives
    game_state = KEEPER;
    wait_active();
    shot_start = 1'b1; shot_zone = 3'd3; tick(); shot_start = 1'b0;
    k = 1;
    while (!is_scored && k < 100) begin tick(); k++; end
    check("to_latency", k, TIMEOUT + 1);
    check("to_goal", 32'(goal), 0);
    check("to_score", 32'(score), 1);

    // Shot on the first WAIT cycle, arrival on the expiry cycle with a mismatch
    wait_active();
    shot_start = 1'b1; shot_zone = 3'd1; tick(); shot_start = 1'b0;
    repeat (TIMEOUT - 1) tick();
    check("coll_no_early", 32'(is_scored), 0);
    ball_arrived = 1'b1; keeper_zone = 3'd4; tick(); ball_arrived = 1'b0;
    check("coll_pulse", 32'(is_scored), 1);
    check("coll_goal", 32'(goal), 1);
    check("coll_score", 32'(score), 1);

    // Shots in GAP, arrival in WAIT, extra shots in FLIGHT are all ignored
    tick();
    shot_start = 1'b1; repeat (3) tick(); shot_start = 1'b0;
    check("gap_active", 32'(round_active), 0);
    wait_active();
    ball_arrived = 1'b1; keeper_zone = 3'd0; tick(); ball_arrived = 1'b0;
    check("wait_arr_pulse", 32'(is_scored), 0);
    shot_start = 1'b1; shot_zone = 3'd5; tick();
    shot_zone = 3'd0; repeat (2) tick(); shot_start = 1'b0;
    ball_arrived = 1'b1; keeper_zone = 3'd5; tick(); ball_arrived = 1'b0;
    check("latched_goal", 32'(goal), 0);
    check("latched_score", 32'(score), 2);

    // Abandoned game mid-flight
    wait_active();
    shot_start = 1'b1; shot_zone = 3'd2; tick(); shot_start = 1'b0;
    repeat (3) tick();
    game_state = START; tick();
    check("mid_pulse", 32'(is_scored), 0);
    check("mid_rc", 32'(round_counter), 0);
    check("mid_score", 32'(score), 0);

    // Reset asserted while a report is on the bus
    game_state = KEEPER;
    wait_active();
    shot_start = 1'b1; shot_zone = 3'd3; tick(); shot_start = 1'b0;
    ball_arrived = 1'b1; keeper_zone = 3'd2; tick(); ball_arrived = 1'b0;
    check("rr_pulse", 32'(is_scored), 1);
    check("rr_goal", 32'(goal), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rr_pulse_low", 32'(is_scored), 0);
    check("rr_goal_low", 32'(goal), 0);

    // Random play
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (hold > 0) hold--;
      else if ($urandom_range(0, 149) == 0) begin
        game_state = g_state'(2'($urandom_range(0, 3)));
        hold = $urandom_range(1, 6);
      end else game_state = KEEPER;
      shot_start   = ($urandom_range(0, 5) == 0);
      shot_zone    = 3'($urandom_range(0, 7));
      ball_arrived = ($urandom_range(0, 11) == 0);
      keeper_zone  = ($urandom_range(0, 1) == 0) ? m_zone : 3'($urandom_range(0, 7));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
